// File: rtl/mem_wb_if.sv
// mem_wb_if: MEM-stage slot inputs and registered writeback outputs
interface mem_wb_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] pc_plus8;
  logic [1:0]        wdata_src;
  logic [1:0]        ld_size;
  logic              ld_unsigned;
  logic              reg_we;
  logic [REG_AW-1:0] reg_waddr;
  logic              wb_valid;
  logic              wb_we;
  logic [REG_AW-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  retire_cnt;
  modport master (
    output in_valid, stall, flush, mem_data, alu_res, pc_plus8,
           wdata_src, ld_size, ld_unsigned, reg_we, reg_waddr,
    input  wb_valid, wb_we, wb_waddr, wb_data, retire_cnt
  );
  modport slave (
    input  in_valid, stall, flush, mem_data, alu_res, pc_plus8,
           wdata_src, ld_size, ld_unsigned, reg_we, reg_waddr,
    output wb_valid, wb_we, wb_waddr, wb_data, retire_cnt
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load alignment and retire counter
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic      clk,
  input logic      rst,
  mem_wb_if.slave  bus
);
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_data;
  logic              w_adv;
  logic              r_valid;
  logic              r_we;
  logic [REG_AW-1:0] r_waddr;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  // pick the addressed byte/half, extend it, then choose the writeback source
  always_comb begin
    w_byte = bus.mem_data[{bus.alu_res[1:0], 3'b000} +: 8];
    w_half = bus.mem_data[{bus.alu_res[1], 4'b0000} +: 16];
    w_load = bus.ld_size == 2'd0 ? {{(DATA_W-8){~bus.ld_unsigned & w_byte[7]}}, w_byte} :
             bus.ld_size == 2'd1 ? {{(DATA_W-16){~bus.ld_unsigned & w_half[15]}}, w_half} :
             bus.mem_data;
    w_data = bus.wdata_src == 2'd0 ? bus.alu_res :
             bus.wdata_src == 2'd1 ? w_load :
             bus.wdata_src == 2'd2 ? bus.pc_plus8 : '0;
    w_adv  = ~bus.stall | bus.flush;
  end
  // slot advances unless stalled; flush bubbles the slot but the leaving instruction still retires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_adv) begin
        r_valid <= ~bus.flush & bus.in_valid;
        r_we    <= ~bus.flush & bus.in_valid & bus.reg_we & (|bus.reg_waddr);
        r_waddr <= bus.reg_waddr;
        r_data  <= w_data;
      end
      if (r_valid & w_adv) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  assign bus.wb_valid   = r_valid;
  assign bus.wb_we      = r_we;
  assign bus.wb_waddr   = r_waddr;
  assign bus.wb_data    = r_data;
  assign bus.retire_cnt = r_cnt;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized and directed checks of mem_wb_stage against a behavioural model
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int errors = 0;
  logic        m_valid, m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_data;
  logic [15:0] m_cnt;
  mem_wb_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) bus ();
  mem_wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_data(input logic [1:0] src, input logic [1:0] size,
      input logic uns, input logic [31:0] mem, input logic [31:0] alu, input logic [31:0] pc);
    logic [31:0] v;
    int off;
    off = int'(alu % 4);
    if (src == 2'd0) return alu;
    if (src == 2'd2) return pc;
    if (src == 2'd3) return 32'd0;
    if (size == 2'd0) begin
      v = (mem >> (8 * off)) & 32'hFF;
      return (uns || v < 128) ? v : v + 32'hFFFFFF00;
    end
    if (size == 2'd1) begin
      v = (mem >> (16 * (off / 2))) & 32'hFFFF;
      return (uns || v < 32768) ? v : v + 32'hFFFF0000;
    end
    return mem;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_waddr = 0; m_data = 0; m_cnt = 0;
  endtask

  task automatic tick();
    logic moves;
    @(posedge clk);
    moves = !bus.stall || bus.flush;
    if (m_valid && moves) m_cnt = m_cnt + 16'd1;
    if (moves) begin
      m_valid = bus.in_valid && !bus.flush;
      m_we    = bus.in_valid && bus.reg_we && bus.reg_waddr != 0 && !bus.flush;
      m_waddr = bus.reg_waddr;
      m_data  = exp_data(bus.wdata_src, bus.ld_size, bus.ld_unsigned, bus.mem_data, bus.alu_res, bus.pc_plus8);
    end
    #1;
  endtask

  task automatic set_in(input logic v, input logic s, input logic f, input logic [1:0] src,
      input logic [1:0] size, input logic uns, input logic [31:0] mem, input logic [31:0] alu,
      input logic we, input logic [4:0] wa);
    bus.in_valid = v; bus.stall = s; bus.flush = f; bus.wdata_src = src; bus.ld_size = size;
    bus.ld_unsigned = uns; bus.mem_data = mem; bus.alu_res = alu; bus.pc_plus8 = $urandom;
    bus.reg_we = we; bus.reg_waddr = wa;
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    vectors++; if ({bus.wb_valid, bus.wb_we} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {bus.wb_valid, bus.wb_we}); end
    vectors++; if (bus.wb_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %h exp 0", bus.wb_waddr); end
    vectors++; if (bus.wb_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.wb_data); end
    vectors++; if (bus.retire_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %h exp 0", bus.retire_cnt); end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_loads();
    set_in(1, 0, 0, 2'b01, 2'b00, 0, 32'h80FF7F01, 32'h3, 1, 5'd7); tick();
    vectors++; if (bus.wb_data !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_signed got %h exp ffffff80", bus.wb_data); end
    vectors++; if (bus.wb_we !== 1'b1 || bus.wb_waddr !== 5'd7) begin errors++; $display("FAIL byte_we got %b/%h exp 1/07", bus.wb_we, bus.wb_waddr); end
    set_in(1, 0, 0, 2'b01, 2'b00, 1, 32'h80FF7F01, 32'h3, 1, 5'd7); tick();
    vectors++; if (bus.wb_data !== 32'h00000080) begin errors++; $display("FAIL byte_unsigned got %h exp 00000080", bus.wb_data); end
    set_in(1, 0, 0, 2'b01, 2'b01, 0, 32'h80017FFE, 32'h2, 1, 5'd7); tick();
    vectors++; if (bus.wb_data !== 32'hFFFF8001) begin errors++; $display("FAIL half_hi got %h exp ffff8001", bus.wb_data); end
    set_in(1, 0, 0, 2'b01, 2'b01, 0, 32'h80017FFE, 32'h0, 1, 5'd7); tick();
    vectors++; if (bus.wb_data !== 32'h00007FFE) begin errors++; $display("FAIL half_lo got %h exp 00007ffe", bus.wb_data); end
    set_in(1, 0, 0, 2'b01, 2'b10, 0, 32'h80017FFE, 32'h3, 1, 5'd7); tick();
    vectors++; if (bus.wb_data !== 32'h80017FFE) begin errors++; $display("FAIL word got %h exp 80017ffe", bus.wb_data); end
    set_in(1, 0, 0, 2'b11, 2'b00, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 5'd7); tick();
    vectors++; if (bus.wb_data !== 32'd0) begin errors++; $display("FAIL src_zero got %h exp 0", bus.wb_data); end
  endtask

  task automatic test_zero_reg();
    logic [15:0] c0;
    set_in(1, 0, 0, 0, 0, 0, 0, 32'h55, 1, 5'd0); tick();
    c0 = bus.retire_cnt === m_cnt ? m_cnt : m_cnt;
    vectors++; if ({bus.wb_valid, bus.wb_we} !== 2'b10) begin errors++; $display("FAIL zero_reg got %b exp 10", {bus.wb_valid, bus.wb_we}); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    vectors++; if (bus.retire_cnt !== c0 + 16'd1) begin errors++; $display("FAIL zero_reg_cnt got %h exp %h", bus.retire_cnt, c0 + 16'd1); end
  endtask

  task automatic test_stall();
    logic [15:0] c0;
    set_in(1, 0, 0, 0, 0, 0, 0, 32'h1234, 1, 5'd3); tick();
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      set_in(1'($urandom), 1, 0, 2'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom), 5'($urandom));
      tick();
      vectors++;
      if ({bus.wb_valid, bus.wb_we, bus.wb_waddr, bus.wb_data, bus.retire_cnt} !== {1'b1, 1'b1, 5'd3, 32'h1234, c0}) begin
        errors++; $display("FAIL stall_hold cyc %0d got v%b we%b a%h d%h c%h exp v1 we1 a03 d00001234 c%h",
          i, bus.wb_valid, bus.wb_we, bus.wb_waddr, bus.wb_data, bus.retire_cnt, c0);
      end
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h9, 0, 0); tick();
    vectors++; if (bus.retire_cnt !== c0 + 16'd1 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL stall_release got c%h v%b exp c%h v0", bus.retire_cnt, bus.wb_valid, c0 + 16'd1); end
  endtask

  task automatic test_flush_stall();
    logic [15:0] c0;
    set_in(1, 0, 0, 0, 0, 0, 0, 32'hAAAA, 1, 5'd4); tick();
    c0 = m_cnt;
    set_in(1, 1, 1, 0, 0, 0, 0, 32'hBBBB, 1, 5'd9); tick();
    vectors++; if ({bus.wb_valid, bus.wb_we} !== 2'b00) begin errors++; $display("FAIL flush_flags got %b exp 00", {bus.wb_valid, bus.wb_we}); end
    vectors++; if (bus.retire_cnt !== c0 + 16'd1) begin errors++; $display("FAIL flush_cnt got %h exp %h", bus.retire_cnt, c0 + 16'd1); end
    vectors++; if (bus.wb_data !== 32'hBBBB || bus.wb_waddr !== 5'd9) begin errors++; $display("FAIL flush_payload got %h/%h exp 0000bbbb/09", bus.wb_data, bus.wb_waddr); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 2'($urandom), 2'($urandom),
        1'($urandom), $urandom, $urandom, 1'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom));
      tick();
      vectors++;
      if ({bus.wb_valid, bus.wb_we, bus.wb_waddr, bus.wb_data, bus.retire_cnt} !== {m_valid, m_we, m_waddr, m_data, m_cnt}) begin
        errors++; $display("FAIL random %0d got v%b we%b a%h d%h c%h exp v%b we%b a%h d%h c%h", i,
          bus.wb_valid, bus.wb_we, bus.wb_waddr, bus.wb_data, bus.retire_cnt, m_valid, m_we, m_waddr, m_data, m_cnt);
      end
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    set_in(1, 0, 0, 0, 0, 0, 0, 32'h1, 1, 5'd1);
    while (m_cnt != 16'hFFFF && n < 70000) begin tick(); n++; end
    vectors++; if (bus.retire_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got %h exp ffff", bus.retire_cnt); end
    tick();
    vectors++; if (bus.retire_cnt !== 16'h0000) begin errors++; $display("FAIL wrap got %h exp 0000", bus.retire_cnt); end
  endtask

  task automatic test_async_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 32'hCAFE, 1, 5'd5); tick();
    bus.stall = 1; tick();
    #2 rst = 1;
    #1;
    vectors++;
    if ({bus.wb_valid, bus.wb_we, bus.wb_waddr, bus.wb_data, bus.retire_cnt} !== 55'd0) begin
      errors++; $display("FAIL async_reset got v%b we%b a%h d%h c%h exp all 0",
        bus.wb_valid, bus.wb_we, bus.wb_waddr, bus.wb_data, bus.retire_cnt);
    end
    #1 rst = 0;
    model_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    vectors++; if (bus.retire_cnt !== 16'd0 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL held_discard got c%h v%b exp c0000 v0", bus.retire_cnt, bus.wb_valid); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_zero_reg();
    test_stall();
    test_flush_stall();
    test_random();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
